seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 129 ++++++++++++
 tb/tb_seg7_scan_decoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Recovers a six-digit BCD clock time from a multiplexed seven-segment display bus.
// Each digit is sampled once its select has been stable, and a frame is published after all six digits pass a range check.
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  scan_select,
    input  logic [6:0]  seg7,
    output logic [23:0] time_bcd,
    output logic        frame_valid,
    output logic        time_changed,
    output logic        seg_err,
    output logic        sel_err,
    output logic        range_err
);

    localparam logic [7:0] SAMPLE_CNT = 8'(STABLE_CYCLES - 1);

    logic [5:0]  prev_sel_q;
    logic [7:0]  stab_cnt_q, stab_cnt_d;
    logic [5:0]  mask_q, mask_d;
    logic [3:0]  shadow_q [6];
    logic [23:0] shadow_flat;
    logic [23:0] time_bcd_q;
    logic        frame_valid_q, time_changed_q, seg_err_q, sel_err_q, range_err_q;

    logic        sel_stable, sample_pt;
    logic [5:0]  sel_act;
    logic        one_sel, multi_sel;
    logic [3:0]  dec_val;
    logic        dec_hit;
    logic        capture, frame_done, range_ok;
    logic [5:0]  cap_en;

    assign sel_stable = (scan_select == prev_sel_q);
    assign sample_pt  = sel_stable && (stab_cnt_q == SAMPLE_CNT);

    // Select is active-low; clearing the lowest set bit leaves something only when two or more digits are driven.
    assign sel_act   = ~scan_select;
    assign multi_sel = |(sel_act & (sel_act - 6'd1));
    assign one_sel   = (sel_act != 6'd0) && !multi_sel;

    always_comb begin
        dec_val = 4'd0;
        dec_hit = 1'b1;
        case (seg7)
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
            default:    dec_hit = 1'b0;
        endcase
    end

    assign capture = sample_pt && one_sel && dec_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            assign cap_en[gi] = capture && sel_act[gi];
            assign shadow_flat[gi*4 +: 4] = shadow_q[gi];

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    shadow_q[gi] <= 4'd0;
                end else if (cap_en[gi]) begin
                    shadow_q[gi] <= dec_val;
                end
            end
        end
    endgenerate

    assign frame_done = (mask_q == 6'h3F);
    assign range_ok   = (shadow_flat[23:20] <= 4'd2) &&
                        (shadow_flat[15:12] <= 4'd5) &&
                        (shadow_flat[7:4]   <= 4'd5) &&
                        ((shadow_flat[23:20] != 4'd2) || (shadow_flat[19:16] <= 4'd3));

    // A capture landing in the completion cycle starts the next frame instead of being dropped.
    assign mask_d = (frame_done ? 6'd0 : mask_q) | cap_en;

    always_comb begin
        stab_cnt_d = 8'd0;
        if (sel_stable) begin
            stab_cnt_d = (stab_cnt_q == 8'hFF) ? stab_cnt_q : stab_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_sel_q     <= 6'h3F;
            stab_cnt_q     <= 8'd0;
            mask_q         <= 6'd0;
            time_bcd_q     <= 24'h000000;
            frame_valid_q  <= 1'b0;
            time_changed_q <= 1'b0;
            seg_err_q      <= 1'b0;
            sel_err_q      <= 1'b0;
            range_err_q    <= 1'b0;
        end else begin
            prev_sel_q     <= scan_select;
            stab_cnt_q     <= stab_cnt_d;
            mask_q         <= mask_d;
            frame_valid_q  <= frame_done && range_ok;
            time_changed_q <= frame_done && range_ok && (shadow_flat != time_bcd_q);
            range_err_q    <= frame_done && !range_ok;
            seg_err_q      <= sample_pt && one_sel && !dec_hit;
            sel_err_q      <= sample_pt && multi_sel;
            if (frame_done && range_ok) begin
                time_bcd_q <= shadow_flat;
            end
        end
    end

    assign time_bcd     = time_bcd_q;
    assign frame_valid  = frame_valid_q;
    assign time_changed = time_changed_q;
    assign seg_err      = seg_err_q;
    assign sel_err      = sel_err_q;
    assign range_err    = range_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: directed scenarios plus random scan traffic,
// checked against a digit/frame level model of the display decoder.
module tb_seg7_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  scan_select;
    logic [6:0]  seg7;
    logic [23:0] time_bcd;
    logic        frame_valid, time_changed, seg_err, sel_err, range_err;

    seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .scan_select  (scan_select),
        .seg7         (seg7),
        .time_bcd     (time_bcd),
        .frame_valid  (frame_valid),
        .time_changed (time_changed),
        .seg_err      (seg_err),
        .sel_err      (sel_err),
        .range_err    (range_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fv;
        logic        tc;
        logic        se;
        logic        sle;
        logic        re;
        logic [23:0] t;
    } ev_t;

    ev_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;

    // Reference model state: digit values, which digits have arrived, published time.
    logic [6:0]  pat [10];
    int          shadow [6];
    logic [5:0]  mask;
    logic [23:0] cur;
    logic [5:0]  last_sel;
    int          run_len;

    initial begin
        pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101;
        pat[3] = 7'b1111001; pat[4] = 7'b0110011; pat[5] = 7'b1011011;
        pat[6] = 7'b1011111; pat[7] = 7'b1110000; pat[8] = 7'b1111111;
        pat[9] = 7'b1111011;
    end

    function automatic int decode(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (pat[i] == s) return i;
        return -1;
    endfunction

    task automatic push_ev(input logic fv, input logic tc, input logic se,
                           input logic sle, input logic re);
        ev_t e;
        e.fv = fv; e.tc = tc; e.se = se; e.sle = sle; e.re = re; e.t = cur;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) shadow[i] = 0;
        mask     = 6'd0;
        cur      = 24'h0;
        last_sel = 6'h3F;
        run_len  = 0;
    endtask

    task automatic model_sample(input logic [5:0] sel, input logic [6:0] s);
        int zeros, idx, d;
        logic [23:0] t;
        zeros = $countones(~sel);
        idx   = 0;
        for (int i = 0; i < 6; i++) if (!sel[i]) idx = i;
        if (zeros > 1) begin
            push_ev(0, 0, 0, 1, 0);
        end else if (zeros == 1) begin
            d = decode(s);
            if (d < 0) begin
                push_ev(0, 0, 1, 0, 0);
            end else begin
                shadow[idx] = d;
                mask[idx]   = 1'b1;
                if (mask == 6'h3F) begin
                    mask = 6'd0;
                    t = {shadow[5][3:0], shadow[4][3:0], shadow[3][3:0],
                         shadow[2][3:0], shadow[1][3:0], shadow[0][3:0]};
                    if (shadow[5] <= 2 && shadow[3] <= 5 && shadow[1] <= 5 &&
                        (shadow[5] != 2 || shadow[4] <= 3)) begin
                        logic chg;
                        chg = (t != cur);
                        cur = t;
                        push_ev(1, chg, 0, 0, 0);
                    end else begin
                        push_ev(0, 0, 0, 0, 1);
                    end
                end
            end
        end
    endtask

    // A select value is sampled on its (S+1)-th consecutive cycle: the change cycle clears the counter.
    task automatic hold(input logic [5:0] sel, input logic [6:0] s, input int len);
        int prev_run;
        prev_run = (sel == last_sel) ? run_len : 0;
        run_len  = prev_run + len;
        last_sel = sel;
        if (prev_run < S + 1 && run_len >= S + 1) model_sample(sel, s);
        scan_select = sel;
        seg7        = s;
        repeat (len) @(negedge clk);
    endtask

    task automatic send_frame(input int d5, input int d4, input int d3,
                              input int d2, input int d1, input int d0, input int len);
        int dg [6];
        dg[5] = d5; dg[4] = d4; dg[3] = d3; dg[2] = d2; dg[1] = d1; dg[0] = d0;
        for (int i = 5; i >= 0; i--) begin
            logic [5:0] m;
            m = 6'd0;
            m[i] = 1'b1;
            hold(~m, pat[dg[i]], len);
        end
        hold(6'h3F, 7'd0, 4);
    endtask

    task automatic do_reset();
        repeat (12) @(negedge clk);
        resetn      = 1'b0;
        scan_select = 6'h3F;
        seg7        = 7'd0;
        repeat (3) @(negedge clk);
        compared++;
        if ({time_bcd, frame_valid, time_changed, seg_err, sel_err, range_err} != 29'd0) begin
            mismatched++;
            $display("FAIL reset_state: got time=%06h pulses=%b%b%b%b%b, need time=000000 pulses=00000",
                     time_bcd, frame_valid, time_changed, seg_err, sel_err, range_err);
        end
        model_reset();
        resetn = 1'b1;
    endtask

    // Monitor: every cycle with any pulse high must match the next expected event.
    always @(negedge clk) begin
        if (resetn === 1'b1 && (frame_valid | time_changed | seg_err | sel_err | range_err)) begin
            ev_t a, e;
            a = {frame_valid, time_changed, seg_err, sel_err, range_err, time_bcd};
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event: got fv/tc/seg/sel/rng=%b%b%b%b%b time=%06h, need no event",
                         a.fv, a.tc, a.se, a.sle, a.re, a.t);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL event: got fv/tc/seg/sel/rng=%b%b%b%b%b time=%06h, need %b%b%b%b%b time=%06h",
                             a.fv, a.tc, a.se, a.sle, a.re, a.t, e.fv, e.tc, e.se, e.sle, e.re, e.t);
                end
                $display("event fv/tc/seg/sel/rng=%b%b%b%b%b time=%06h", a.fv, a.tc, a.se, a.sle, a.re, a.t);
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        scan_select = 6'h3F;
        seg7        = 7'd0;
        model_reset();
        do_reset();

        send_frame(1, 2, 3, 4, 5, 6, 8);
        send_frame(1, 2, 3, 4, 5, 6, 8);
        send_frame(0, 1, 2, 3, 4, 5, 3);

        // Bad pattern on min_l, then the rest of the frame, then a good min_l rescan.
        hold(6'b011111, pat[2], 8);
        hold(6'b101111, pat[0], 8);
        hold(6'b110111, pat[4], 8);
        hold(6'b111011, 7'b0000001, 8);
        hold(6'b111101, pat[3], 8);
        hold(6'b111110, pat[9], 8);
        hold(6'b111011, pat[1], 8);
        hold(6'h3F, 7'd0, 4);

        send_frame(2, 5, 0, 0, 0, 0, 8);
        hold(6'b001111, pat[0], 8);
        hold(6'h3F, 7'd0, 4);

        hold(6'b011111, pat[1], 8);
        hold(6'b101111, pat[1], 8);
        hold(6'b110111, pat[1], 8);
        do_reset();
        send_frame(0, 9, 3, 0, 1, 5, 8);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] sel, m;
            logic [6:0] s;
            int r, a, b, idx, d;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                sel = 6'h3F;
            end else if (r == 1) begin
                a = int'($urandom_range(0, 5));
                b = (a + 1 + int'($urandom_range(0, 4))) % 6;
                m = 6'd0; m[a] = 1'b1; m[b] = 1'b1;
                sel = ~m;
            end else begin
                idx = int'($urandom_range(0, 5));
                m = 6'd0; m[idx] = 1'b1;
                sel = ~m;
            end
            idx = 0;
            for (int i = 0; i < 6; i++) if (!sel[i]) idx = i;
            r = int'($urandom_range(0, 11));
            if (r == 0)      s = 7'($urandom);
            else if (r == 1) s = pat[$urandom_range(0, 9)];
            else begin
                case (idx)
                    5:       d = int'($urandom_range(0, 2));
                    4:       d = int'($urandom_range(0, 3));
                    3, 1:    d = int'($urandom_range(0, 5));
                    default: d = int'($urandom_range(0, 9));
                endcase
                s = pat[d];
            end
            hold(sel, s, int'($urandom_range(2, 8)));
        end
        hold(6'h3F, 7'd0, 20);

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL pending_events: got %0d still outstanding, need 0", exp_q.size());
        end
        compared++;
        if (time_bcd !== cur) begin
            mismatched++;
            $display("FAIL final_time: got %06h, need %06h", time_bcd, cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
